imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Arbitrates and sequences access to the single-port instruction memory (DEPTH x 32-bit words, synchronous read) between two requesters:
  - the core's instruction-fetch port;
  - a program-loader/debug port that can read and write.
- Handles grant policy, starvation avoidance, a loader lock mode, address range checking and response routing.
- Sits between the fetch stage, the loader and the memory macro.

Parameters:
- ADDR_W, 32, byte-address width of both requester ports
- DEPTH, 1024, memory depth in 32-bit words (power of two)
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced a grant (1..15)

Ports:
- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous active-high reset
- fetch_req  in  1  fetch read request
- fetch_addr  in  ADDR_W  fetch byte address
- fetch_gnt  out  1  fetch request accepted this cycle (combinational)
- fetch_rvalid  out  1  fetch read data valid
- fetch_rdata  out  32  fetch read data
- fetch_err  out  1  out-of-range fetch, valid with fetch_rvalid
- ldr_req  in  1  loader request
- ldr_we  in  1  1 = write, 0 = read
- ldr_addr  in  ADDR_W  loader byte address
- ldr_wdata  in  32  loader write data
- ldr_lock  in  1  request exclusive memory ownership (blocks fetch)
- ldr_gnt  out  1  loader request accepted this cycle (combinational)
- ldr_rvalid  out  1  loader read data valid, or write-error report
- ldr_rdata  out  32  loader read data
- ldr_err  out  1  out-of-range loader access, valid with ldr_rvalid
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  log2(DEPTH)  memory word index
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, one cycle after mem_en && !mem_we

Behaviour:
- Reset:
  - All outputs 0; FSM in RUN; starve counter 0.
  - Any response owed from a grant in the reset cycle is cancelled: no rvalid in the following cycle.
- Addressing:
  - Word index = addr[log2(DEPTH)+1:2]; addr[1:0] ignored.
  - Out of range when addr[ADDR_W-1:2] >= DEPTH.
- Handshake:
  - Requester holds req, addr, we and wdata stable until gnt.
  - gnt is combinational in the same cycle; at most one grant per cycle.
  - A granted in-range access drives mem_en/mem_we/mem_addr/mem_wdata in that same cycle.
- Read latency:
  - rvalid asserts exactly 1 cycle after the grant for the winner only.
  - rdata = mem_rdata; rdata is 0 whenever rvalid is 0.
- Out-of-range accesses:
  - Granted normally, but mem_en stays 0.
  - Read: rvalid with rdata 0 and err=1 the next cycle.
  - Write: dropped; ldr_rvalid with ldr_err=1 the next cycle.
  - In-range write: no rvalid; gnt is completion.
- Arbitration in RUN:
  - Loader has priority over fetch, except when starve_cnt == STARVE_LIMIT; then fetch wins that cycle.
  - starve_cnt increments each cycle fetch_req && !fetch_gnt, saturating at STARVE_LIMIT.
  - starve_cnt clears on any fetch grant or when fetch_req = 0.
- FSM states:
  - RUN: arbitration as above. Goes to LOCK on the cycle after ldr_lock sampled 1.
  - LOCK: fetch_gnt forced 0; starve_cnt held at 0; only the loader is granted. Goes to RUN on the cycle after ldr_lock sampled 0.
  - A fetch read granted in the cycle lock is sampled still returns its rvalid.
- Simultaneous events:
  - Loader write and fetch read to the same word in one cycle: only the winner is granted. The loser retries and reads the new data.
  - ldr_lock toggling every cycle is legal: state follows ldr_lock delayed by one cycle.
- Reset mid-operation:
  - Overrides lock, starve count and pending responses.
  - The memory array contents are not affected.

Optional Feature:
- IMEM_ARB_STATS_EN defined:
  - Adds outputs stat_fetch_stall (32-bit) and stat_starve_force (16-bit).
  - stat_fetch_stall counts cycles with fetch_req && !fetch_gnt.
  - stat_starve_force counts forced fetch grants.
  - Both counters saturate, and clear on reset.
- Macro undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Preload word i = i*4. Fetch 0x8 alone -> fetch_gnt same cycle; fetch_rvalid next cycle with rdata 0x00000008; fetch_err 0.
- Loader write 0xDEADBEEF to 0x10 and fetch 0x10 in the same cycle -> ldr_gnt=1, fetch_gnt=0, mem_we=1, mem_addr=4. Fetch granted next cycle, returns 0xDEADBEEF.
- Loader requests every cycle, fetch_req held, STARVE_LIMIT=4 -> fetch denied 4 cycles, granted on the 5th. Repeats every 5 cycles.
- ldr_lock=1 with fetch_req held for 10 cycles -> fetch_gnt 0 throughout after the first cycle. Drop ldr_lock -> fetch granted within 2 cycles.
- Fetch 0x1000 (DEPTH=1024) -> granted, mem_en 0, next cycle fetch_rvalid=1, rdata 0, fetch_err=1. Loader write to 0xFFFC0 -> ldr_rvalid=1, ldr_err=1, memory unchanged.
- Fetch granted, reset=1 in that same cycle -> no fetch_rvalid the next cycle; all outputs 0; FSM RUN. Memory word still reads the preloaded value afterwards.

Source files
------------

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Shares one single-port instruction memory (DEPTH x 32-bit, synchronous
// read) between the core's instruction-fetch port and a program-loader/debug
// port. Covers grant policy, fetch starvation avoidance, a loader lock mode,
// address range checking and routing of read responses.
//
// Optional build feature: define IMEM_ARB_STATS_EN to add the saturating
// statistics outputs stat_fetch_stall and stat_starve_force.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   fetch_req/addr       fetch read request and byte address
//   fetch_gnt            fetch request accepted this cycle (combinational)
//   fetch_rvalid/rdata   fetch response, one cycle after the grant
//   fetch_err            out-of-range fetch, valid with fetch_rvalid
//   ldr_req/we/addr      loader request, write select, byte address
//   ldr_wdata            loader write data
//   ldr_lock             loader requests exclusive ownership (blocks fetch)
//   ldr_gnt              loader request accepted this cycle (combinational)
//   ldr_rvalid/rdata     loader read response, or out-of-range write report
//   ldr_err              out-of-range loader access, valid with ldr_rvalid
//   mem_en/we/addr/wdata memory macro controls (word index on mem_addr)
//   mem_rdata            memory read data, one cycle after a read enable
//   stat_fetch_stall     (IMEM_ARB_STATS_EN) cycles fetch waited
//   stat_starve_force    (IMEM_ARB_STATS_EN) forced fetch grants
// -----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DEPTH        = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       fetch_req,
    input  logic [ADDR_W-1:0]          fetch_addr,
    output logic                       fetch_gnt,
    output logic                       fetch_rvalid,
    output logic [31:0]                fetch_rdata,
    output logic                       fetch_err,

    input  logic                       ldr_req,
    input  logic                       ldr_we,
    input  logic [ADDR_W-1:0]          ldr_addr,
    input  logic [31:0]                ldr_wdata,
    input  logic                       ldr_lock,
    output logic                       ldr_gnt,
    output logic                       ldr_rvalid,
    output logic [31:0]                ldr_rdata,
    output logic                       ldr_err,

    output logic                       mem_en,
    output logic                       mem_we,
    output logic [$clog2(DEPTH)-1:0]   mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic [31:0]                mem_rdata
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [31:0]                stat_fetch_stall,
    output logic [15:0]                stat_starve_force
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    // Word-address limit expressed at port width for the range compare.
    localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
    localparam logic [3:0]        STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;

    logic        fetch_rvalid_q, fetch_rvalid_d;
    logic        fetch_err_q,    fetch_err_d;
    logic        ldr_rvalid_q,   ldr_rvalid_d;
    logic        ldr_err_q,      ldr_err_d;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic              fetch_oor, ldr_oor;
    logic [IDX_W-1:0]  fetch_idx, ldr_idx;

    assign fetch_oor = {2'b00, fetch_addr[ADDR_W-1:2]} >= DEPTH_A;
    assign ldr_oor   = {2'b00, ldr_addr[ADDR_W-1:2]}   >= DEPTH_A;
    assign fetch_idx = fetch_addr[IDX_W+1:2];
    assign ldr_idx   = ldr_addr[IDX_W+1:2];

    // Byte-lane bits are deliberately ignored; word accesses only.
    logic unused_byte_bits;
    assign unused_byte_bits = ^{fetch_addr[1:0], ldr_addr[1:0]};

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic fetch_gnt_c, ldr_gnt_c, starve_force;

    // Fetch wins outright once it has waited STARVE_LIMIT cycles in a row.
    assign starve_force = (state_q == ST_RUN) && fetch_req &&
                          (starve_cnt_q == STARVE_MAX);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        fetch_gnt_c = 1'b0;
        ldr_gnt_c   = 1'b0;
        if (state_q == ST_LOCK) begin
            ldr_gnt_c = ldr_req;
        end else if (starve_force) begin
            fetch_gnt_c = 1'b1;
        end else if (ldr_req) begin
            ldr_gnt_c = 1'b1;
        end else begin
            fetch_gnt_c = fetch_req;
        end
    end

    assign fetch_gnt = fetch_gnt_c;
    assign ldr_gnt   = ldr_gnt_c;

    // -------------------------------------------------------------------------
    // Memory drive: the single winner owns the port; out-of-range is masked.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ldr_gnt_c && !ldr_oor) begin
            mem_en   = 1'b1;
            mem_we   = ldr_we;
            mem_addr = ldr_idx;
            if (ldr_we) begin
                mem_wdata = ldr_wdata;
            end
        end else if (fetch_gnt_c && !fetch_oor) begin
            mem_en   = 1'b1;
            mem_addr = fetch_idx;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Lock mode tracks ldr_lock one cycle late, even if it toggles.
        state_d = ldr_lock ? ST_LOCK : ST_RUN;

        starve_cnt_d = starve_cnt_q;
        if (state_q == ST_LOCK || !fetch_req || fetch_gnt_c) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        // Responses owed next cycle. An in-range write completes at grant and
        // produces no response; an out-of-range write reports an error.
        fetch_rvalid_d = fetch_gnt_c;
        fetch_err_d    = fetch_gnt_c && fetch_oor;
        ldr_rvalid_d   = ldr_gnt_c && (!ldr_we || ldr_oor);
        ldr_err_d      = ldr_gnt_c && ldr_oor;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Clearing the response flops cancels anything granted this cycle.
            state_q        <= ST_RUN;
            starve_cnt_q   <= '0;
            fetch_rvalid_q <= 1'b0;
            fetch_err_q    <= 1'b0;
            ldr_rvalid_q   <= 1'b0;
            ldr_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            starve_cnt_q   <= starve_cnt_d;
            fetch_rvalid_q <= fetch_rvalid_d;
            fetch_err_q    <= fetch_err_d;
            ldr_rvalid_q   <= ldr_rvalid_d;
            ldr_err_q      <= ldr_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Response routing: data passes only for a valid, in-range read; zero
    // otherwise so idle or error responses never leak stale memory data.
    // -------------------------------------------------------------------------
    assign fetch_rvalid = fetch_rvalid_q;
    assign fetch_err    = fetch_err_q;
    assign fetch_rdata  = (fetch_rvalid_q && !fetch_err_q) ? mem_rdata : 32'd0;

    assign ldr_rvalid   = ldr_rvalid_q;
    assign ldr_err      = ldr_err_q;
    assign ldr_rdata    = (ldr_rvalid_q && !ldr_err_q) ? mem_rdata : 32'd0;

`ifdef IMEM_ARB_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating statistics
    // -------------------------------------------------------------------------
    logic [31:0] stat_fetch_stall_q,  stat_fetch_stall_d;
    logic [15:0] stat_starve_force_q, stat_starve_force_d;

    always_comb begin
        stat_fetch_stall_d  = stat_fetch_stall_q;
        stat_starve_force_d = stat_starve_force_q;
        if (fetch_req && !fetch_gnt_c && (stat_fetch_stall_q != '1)) begin
            stat_fetch_stall_d = stat_fetch_stall_q + 32'd1;
        end
        if (starve_force && (stat_starve_force_q != '1)) begin
            stat_starve_force_d = stat_starve_force_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetch_stall_q  <= '0;
            stat_starve_force_q <= '0;
        end else begin
            stat_fetch_stall_q  <= stat_fetch_stall_d;
            stat_starve_force_q <= stat_starve_force_d;
        end
    end

    assign stat_fetch_stall  = stat_fetch_stall_q;
    assign stat_starve_force = stat_starve_force_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Directed bench for imem_arbiter with a behavioural synchronous-read memory.
// Inputs are driven and outputs sampled around the falling edge, away from
// the rising edge that updates the design.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 1024;
    localparam int IDX_W  = $clog2(DEPTH);

    logic               clk;
    logic               reset;
    logic               fetch_req;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               fetch_gnt, fetch_rvalid, fetch_err;
    logic [31:0]        fetch_rdata;
    logic               ldr_req, ldr_we, ldr_lock;
    logic [ADDR_W-1:0]  ldr_addr;
    logic [31:0]        ldr_wdata;
    logic               ldr_gnt, ldr_rvalid, ldr_err;
    logic [31:0]        ldr_rdata;
    logic               mem_en, mem_we;
    logic [IDX_W-1:0]   mem_addr;
    logic [31:0]        mem_wdata, mem_rdata;
`ifdef IMEM_ARB_STATS_EN
    logic [31:0]        stat_fetch_stall;
    logic [15:0]        stat_starve_force;
`endif

    int total = 0;
    int bad   = 0;

    imem_arbiter #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt),
        .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata), .ldr_err(ldr_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_STATS_EN
        ,
        .stat_fetch_stall(stat_fetch_stall), .stat_starve_force(stat_starve_force)
`endif
    );

    // Behavioural memory macro.
    // NOTE: the storage array has no reset; only control state is reset, so
    // memory contents survive a reset of the arbiter.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        fetch_req = 1'b0; fetch_addr = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i * 4);
        mem_rdata = '0;
        reset = 1'b1; ldr_lock = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;

        // ---- reset state ----
        check("rst_fetch_rvalid", fetch_rvalid, 0);
        check("rst_ldr_rvalid",   ldr_rvalid, 0);
        check("rst_fetch_rdata",  fetch_rdata, 0);
        check("rst_ldr_rdata",    ldr_rdata, 0);
        check("rst_errs",         {fetch_err, ldr_err}, 0);
        check("rst_mem_ctl",      {mem_en, mem_we, mem_addr}, 0);
        check("rst_gnts",         {fetch_gnt, ldr_gnt}, 0);
`ifdef IMEM_ARB_STATS_EN
        check("rst_stats", {stat_fetch_stall, stat_starve_force}, 0);
`endif

        // ---- simple fetch of 0x8 ----
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'h8;
        #1;
        check("f8_gnt",      fetch_gnt, 1);
        check("f8_mem_en",   mem_en, 1);
        check("f8_mem_addr", mem_addr, 2);
        @(negedge clk);
        check("f8_rvalid", fetch_rvalid, 1);
        check("f8_rdata",  fetch_rdata, 32'h8);
        check("f8_err",    fetch_err, 0);
        idle_inputs();

        // ---- loader write vs fetch read of the same word ----
        @(negedge clk);
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h10; ldr_wdata = 32'hDEADBEEF;
        fetch_req = 1'b1; fetch_addr = 32'h10;
        #1;
        check("coll_ldr_gnt",   ldr_gnt, 1);
        check("coll_fetch_gnt", fetch_gnt, 0);
        check("coll_mem_we",    mem_we, 1);
        check("coll_mem_addr",  mem_addr, 4);
        @(negedge clk);
        ldr_req = 1'b0; ldr_we = 1'b0;
        check("coll_wr_no_rvalid", ldr_rvalid, 0);
        #1;
        check("coll_retry_gnt", fetch_gnt, 1);
        @(negedge clk);
        check("coll_rvalid", fetch_rvalid, 1);
        check("coll_rdata",  fetch_rdata, 32'hDEADBEEF);
        idle_inputs();

        // ---- starvation: loader every cycle, fetch held ----
        @(negedge clk);
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h0;
        fetch_req = 1'b1; fetch_addr = 32'h4;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("starve_fetch_gnt_%0d", i), fetch_gnt, (i % 5 == 4));
            check($sformatf("starve_ldr_gnt_%0d", i),   ldr_gnt,   (i % 5 != 4));
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);

        // ---- lock mode ----
        ldr_lock = 1'b1; fetch_req = 1'b1; fetch_addr = 32'hC;
        #1;
        check("lock_first_gnt", fetch_gnt, 1);
        @(negedge clk);
        check("lock_first_rvalid", fetch_rvalid, 1);
        check("lock_first_rdata",  fetch_rdata, 32'hC);
        for (int i = 1; i < 10; i++) begin
            #1;
            check($sformatf("lock_blocked_%0d", i), fetch_gnt, 0);
            @(negedge clk);
        end
        ldr_lock = 1'b0;
        #1;
        check("unlock_still_locked", fetch_gnt, 0);
        @(negedge clk);
        #1;
        check("unlock_gnt", fetch_gnt, 1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        // ---- out-of-range fetch ----
        fetch_req = 1'b1; fetch_addr = 32'h1000;
        #1;
        check("oor_f_gnt",    fetch_gnt, 1);
        check("oor_f_mem_en", mem_en, 0);
        @(negedge clk);
        idle_inputs();
        check("oor_f_rvalid", fetch_rvalid, 1);
        check("oor_f_rdata",  fetch_rdata, 0);
        check("oor_f_err",    fetch_err, 1);

        // ---- out-of-range loader write ----
        @(negedge clk);
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'hFFFC0; ldr_wdata = 32'h12345678;
        #1;
        check("oor_w_gnt",    ldr_gnt, 1);
        check("oor_w_mem_en", mem_en, 0);
        @(negedge clk);
        idle_inputs();
        check("oor_w_rvalid", ldr_rvalid, 1);
        check("oor_w_err",    ldr_err, 1);
        check("oor_w_rdata",  ldr_rdata, 0);
        check("oor_w_mem_kept", mem[1008], 32'hFC0);

        // ---- in-range loader read ----
        @(negedge clk);
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'hFC0;
        #1;
        check("lrd_gnt", ldr_gnt, 1);
        @(negedge clk);
        idle_inputs();
        check("lrd_rvalid", ldr_rvalid, 1);
        check("lrd_rdata",  ldr_rdata, 32'hFC0);
        check("lrd_err",    ldr_err, 0);

        // ---- reset in the grant cycle cancels the response ----
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'h8; reset = 1'b1;
        #1;
        check("rstg_gnt", fetch_gnt, 1);
        @(negedge clk);
        reset = 1'b0; idle_inputs();
        check("rstg_no_rvalid", fetch_rvalid, 0);
        check("rstg_rdata",     fetch_rdata, 0);
        check("rstg_err",       fetch_err, 0);

        // ---- reset overrides lock ----
        @(negedge clk);
        ldr_lock = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; ldr_lock = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h8;
        #1;
        check("rstlock_run_gnt", fetch_gnt, 1);
        @(negedge clk);
        idle_inputs();
        check("rstlock_rvalid", fetch_rvalid, 1);
        check("rstlock_mem_kept", fetch_rdata, 32'h8);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
